// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the multiply/divide unit, the ALU and the
// main controller decode.
//   FUNCT_*  : MIPS R-type funct codes handled by the mul/div unit
//   state_t  : mul/div sequencer state encoding (ST_IDLE, ST_RUN, ST_FIX)
package mips_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/mips_muldiv_step.sv
// mips_muldiv_step: one combinational iteration of the mul/div datapath on
// the {acc, q} register pair.
//   multiply : if q[0], acc += m; then {acc,q} shifts right one bit
//   divide   : restoring step; {acc,q} shifts left one bit, m is subtracted
//              from the upper part if it fits and the quotient bit enters q[0]
// Ports:
//   is_div       in   select divide step (1) or multiply step (0)
//   acc, q, m    in   accumulator, shift register, multiplicand/divisor
//   acc_n, q_n   out  next accumulator / shift register
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] q_n
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, m};
        // partial remainder is {acc, q[msb]}; the borrow out (diff msb) means m did not fit
        diff = {acc, q[WIDTH-1]} - {1'b0, m};
        acc_n = '0;
        q_n   = '0;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                q_n   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = {acc[WIDTH-2:0], q[WIDTH-1]};
                q_n   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q[0]) {acc_n, q_n} = {sum, q[WIDTH-1:1]};
            else      {acc_n, q_n} = {1'b0, acc, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU (one bit per cycle) plus
// single-cycle MTHI/MTLO, owning the HI/LO registers.
// Signed operations run on magnitudes; the sign is applied in the FIX cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, funct  issue request (taken only when idle) and MIPS funct code
//   in1, in2      rs / rt operands
//   busy          operation in flight
//   done, div0    result pulse; div0 flags a zero divisor
//   hi, lo        HI / LO registers
// Build option: MULDIV_EARLY_TERM_EN lets multiplies leave RUN once the
// remaining multiplier bits are all zero; the FIX cycle then performs the
// skipped right shifts in one go.
import mips_pkg::*;

module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] acc, q, m, acc_n, q_n;
    logic             is_div, neg_q, neg_r, dz;
    logic             op_mul, op_div, op_signed, a_neg, b_neg, run_last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;

    assign busy = (state != ST_IDLE);

    always_comb begin
        op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
        op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        a_neg     = op_signed & in1[WIDTH-1];
        b_neg     = op_signed & in2[WIDTH-1];
        a_mag     = a_neg ? -in1 : in1;
        b_mag     = b_neg ? -in2 : in2;
    end

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .q      (q),
        .m      (m),
        .acc_n  (acc_n),
        .q_n    (q_n)
    );

    assign cnt_n = cnt + CW'(1);

`ifdef MULDIV_EARLY_TERM_EN
    // after cnt_n steps the unconsumed multiplier bits sit in q_n[WIDTH-1-cnt_n:0]
    logic [CW-1:0] sh;
    assign sh       = CW'(WIDTH) - cnt;
    assign run_last = (cnt_n == CW'(WIDTH)) ||
                      (!is_div && ((q_n & ({WIDTH{1'b1}} >> cnt_n)) == '0));
    assign prod     = {acc, q} >> sh;
`else
    assign run_last = (cnt_n == CW'(WIDTH));
    assign prod     = {acc, q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_mul || op_div) begin
                            acc    <= '0;
                            cnt    <= '0;
                            q      <= op_div ? a_mag : b_mag;
                            m      <= op_div ? b_mag : a_mag;
                            is_div <= op_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dz     <= op_div && (in2 == '0);
                            state  <= ST_RUN;
                        end else if (funct == FUNCT_MTHI) begin
                            hi   <= in1;
                            done <= 1'b1;
                        end else if (funct == FUNCT_MTLO) begin
                            lo   <= in1;
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    cnt <= cnt_n;
                    if (run_last) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (is_div) begin
                        // zero divisor: quotient all ones; restoring leaves |in1| in acc,
                        // so the dividend-sign fix below returns in1 unchanged.
                        // MIN_INT/-1 falls out naturally: -(0x80..0) == 0x80..0.
                        lo   <= dz ? '1 : (neg_q ? -q : q);
                        hi   <= neg_r ? -acc : acc;
                        div0 <= dz;
                    end else begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit: table-driven vectors plus random ops
// checked against a behavioural model, with a scoreboard queue of expected
// results, and hand-written sequences for reset abort, busy-ignore, MTHI/MTLO
// and invalid funct.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, busy, done, div0;
    logic [5:0]   funct;
    logic [W-1:0] in1, in2, hi, lo;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a, b, ehi, elo;
        logic         ed0;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         d0;
        logic         mul;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    vec_t         vt[$];
    int           tests = 0, fails = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic d);
        longint sa, sb2;
        logic [63:0] p;
        int ia, ib;
        d = 1'b0; h = '0; l = '0;
        sa = longint'($signed(a)); sb2 = longint'($signed(b));
        ia = $signed(a); ib = $signed(b);
        case (f)
            FUNCT_MULT:  begin p = sa * sb2; {h, l} = p; end
            FUNCT_MULTU: begin p = {32'b0, a} * {32'b0, b}; {h, l} = p; end
            FUNCT_DIV: begin
                if (b == 0) begin h = a; l = '1; d = 1'b1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = '0; l = a; end
                else begin l = ia / ib; h = ia % ib; end
            end
            FUNCT_DIVU: begin
                if (b == 0) begin h = a; l = '1; d = 1'b1; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Caller is at a negedge. Drives the request, waits for done, pops and
    // checks. inj>1 injects an MTHI start at cycle inj (must be ignored).
    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic ed0, input int inj, input int maxlat);
        exp_t e;
        int   n;
        bit   seen;
        e.hi  = ehi; e.lo = elo; e.d0 = ed0;
        e.mul = (f == FUNCT_MULT) || (f == FUNCT_MULTU);
        e.lat = (maxlat != 0) ? maxlat : ((f == FUNCT_MTHI || f == FUNCT_MTLO) ? 1 : W + 2);
        sb.push_back(e);
        m_hi = ehi; m_lo = elo;
        start = 1'b1; funct = f; in1 = a; in2 = b;
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1 || (inj > 1 && n == inj + 1)) start = 1'b0;
            if (inj > 1 && n == inj) begin start = 1'b1; funct = FUNCT_MTHI; in1 = 32'hDEAD; end
            if (done) begin
                seen = 1;
                e = sb.pop_front();
                chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
                chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
                chk({tag, "_div0"}, 64'(div0), 64'(e.d0));
                if (e.lat == 1) chk({tag, "_busy"}, 64'(busy), 64'(0));
`ifdef MULDIV_EARLY_TERM_EN
                if (e.mul) chk({tag, "_lat_max"}, 64'(n <= e.lat), 64'(1));
                else       chk({tag, "_latency"}, 64'(n), 64'(e.lat));
`else
                chk({tag, "_latency"}, 64'(n), 64'(e.lat));
`endif
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, n);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int           dcnt;
        logic [5:0]   rf;
        logic [W-1:0] ra, rb, rh, rl;
        logic         rd;

        rst = 1'b1; start = 1'b0; funct = '0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        rst = 1'b0;

        vt.push_back('{FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        vt.push_back('{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vt.push_back('{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vt.push_back('{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        vt.push_back('{FUNCT_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1});
        vt.push_back('{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vt.push_back('{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
        vt.push_back('{FUNCT_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0});
        vt.push_back('{FUNCT_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1});
        vt.push_back('{FUNCT_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0});
        vt.push_back('{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0});
        vt.push_back('{FUNCT_MULT,  32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0});
        vt.push_back('{FUNCT_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 1'b0});

        // ops chain: each new start is driven in the done cycle of the previous one
        @(negedge clk);
        foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b,
                               vt[i].ehi, vt[i].elo, vt[i].ed0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rf = FUNCT_MULT + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 20)) : W'($urandom));
            model(rf, ra, rb, rh, rl, rd);
            run_op($sformatf("rnd%0d", i), rf, ra, rb, rh, rl, rd, 0, 0);
        end

        // MTHI then MTLO back-to-back
        run_op("mthi", FUNCT_MTHI, 32'h1234, 32'h0, 32'h1234, m_lo, 1'b0, 0, 0);
        run_op("mtlo", FUNCT_MTLO, 32'hABCD, 32'h0, 32'h1234, 32'hABCD, 1'b0, 0, 0);

        // start during busy is ignored
        run_op("busy_ign", FUNCT_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 5, 0);
        dcnt = 0;
        repeat (3) begin @(negedge clk); if (done) dcnt++; end
        chk("busy_ign_no_extra_done", 64'(dcnt), 64'(0));
        chk("busy_ign_hi_hold", 64'(hi), 64'(5));

        // invalid funct ignored
        start = 1'b1; funct = 6'b100000; in1 = 32'h5555; in2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        repeat (4) begin if (done || busy) dcnt++; @(negedge clk); end
        chk("badfunct_quiet", 64'(dcnt), 64'(0));
        chk("badfunct_hi", 64'(hi), 64'(m_hi));
        chk("badfunct_lo", 64'(lo), 64'(m_lo));

        // reset mid-DIV aborts without done
        start = 1'b1; funct = FUNCT_DIV; in1 = 32'd100; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("middiv_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        chk("abort_no_done", 64'(dcnt), 64'(0));
        run_op("post_rst_mult", FUNCT_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, 0);

`ifdef MULDIV_EARLY_TERM_EN
        run_op("early_9x1", FUNCT_MULTU, 32'd9, 32'd1, 32'd0, 32'd9, 1'b0, 0, 3);
        run_op("early_div", FUNCT_DIVU, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
